// File: rtl/rtc_update_mc_if.sv
// Bus bundle for rtc_update_mc: load/match/count requests in, RTC results out.
// RTC_UPDATE_TESTOFFSET_EN adds the TESTOFFSET/RTCTOFFSET test-override pair.
interface rtc_update_mc_if #(
  parameter int unsigned CW        = 32,
  parameter int unsigned NUM_MATCH = 4
);
  logic [CW-1:0]           CountSync;
  logic [CW-1:0]           RTCLR;
  logic [NUM_MATCH*CW-1:0] RTCMR;
  logic                    RTCEn;
  logic                    WrenRTCLR;
  logic [NUM_MATCH-1:0]    WrenRTCMR;
  logic                    CountEdge;
  logic [CW-1:0]           RtcValue;
  logic [CW-1:0]           Offset;
  logic [NUM_MATCH*CW-1:0] MatchData;
  logic [NUM_MATCH-1:0]    MatchHit;
  logic                    Busy;
`ifdef RTC_UPDATE_TESTOFFSET_EN
  logic                    TESTOFFSET;
  logic [CW-1:0]           RTCTOFFSET;

  modport slave (
    input  CountSync, RTCLR, RTCMR, RTCEn, WrenRTCLR, WrenRTCMR, CountEdge, TESTOFFSET, RTCTOFFSET,
    output RtcValue, Offset, MatchData, MatchHit, Busy
  );
  modport master (
    output CountSync, RTCLR, RTCMR, RTCEn, WrenRTCLR, WrenRTCMR, CountEdge, TESTOFFSET, RTCTOFFSET,
    input  RtcValue, Offset, MatchData, MatchHit, Busy
  );
`else
  modport slave (
    input  CountSync, RTCLR, RTCMR, RTCEn, WrenRTCLR, WrenRTCMR, CountEdge,
    output RtcValue, Offset, MatchData, MatchHit, Busy
  );
  modport master (
    output CountSync, RTCLR, RTCMR, RTCEn, WrenRTCLR, WrenRTCMR, CountEdge,
    input  RtcValue, Offset, MatchData, MatchHit, Busy
  );
`endif
endinterface

// File: rtl/rtc_update_mc.sv
// Multi-cycle RTC update engine: one shared adder computes offset, RTC value and match values.
// Optional test-offset override enabled by defining RTC_UPDATE_TESTOFFSET_EN.
module rtc_update_mc #(
  parameter int unsigned CW        = 32,
  parameter int unsigned NUM_MATCH = 4
) (
  input logic            PCLK,
  input logic            POR,
  rtc_update_mc_if.slave rtc_io
);

  typedef enum logic [1:0] {StIdle, StOffset, StRtcValue, StMatch} state_e;

  state_e                  state_q, state_d;
  logic                    load_pend_q, load_pend_d;
  logic                    count_pend_q, count_pend_d;
  logic [NUM_MATCH-1:0]    match_pend_q, match_pend_d;
  logic [NUM_MATCH-1:0]    match_hit_q, match_hit_d;
  logic [NUM_MATCH-1:0]    match_sel;
  logic [CW-1:0]           offset_q, offset_d;
  logic [CW-1:0]           rtc_value_q, rtc_value_d;
  logic [NUM_MATCH*CW-1:0] match_data_q, match_data_d;
  logic                    busy_q, busy_d;
  logic [CW-1:0]           add_a, add_b, add_sum, sel_mr;
  logic                    add_cin;
  logic                    test_en;
  logic [CW-1:0]           test_val;

`ifdef RTC_UPDATE_TESTOFFSET_EN
  assign test_en  = rtc_io.TESTOFFSET;
  assign test_val = rtc_io.RTCTOFFSET;
`else
  assign test_en  = 1'b0;
  assign test_val = '0;
`endif

  // Lowest pending channel is serviced first.
  assign match_sel = match_pend_q & (-match_pend_q);

  always_comb begin
    sel_mr = '0;
    for (int i = 0; i < int'(NUM_MATCH); i++) begin
      if (match_sel[i]) sel_mr = sel_mr | rtc_io.RTCMR[i*CW +: CW];
    end
  end

  // Shared adder; subtraction is a + ~b + 1.
  always_comb begin
    add_a   = rtc_io.CountSync;
    add_b   = ~rtc_io.RTCLR;
    add_cin = 1'b1;
    case (state_q)
      StRtcValue: add_b = ~offset_q;
      StMatch: begin
        add_a   = sel_mr;
        add_b   = offset_q;
        add_cin = 1'b0;
      end
      default: ;
    endcase
  end

  assign add_sum = add_a + add_b + CW'(add_cin);

  always_comb begin
    load_pend_d  = load_pend_q | rtc_io.WrenRTCLR;
    count_pend_d = count_pend_q | rtc_io.CountEdge;
    match_pend_d = match_pend_q | rtc_io.WrenRTCMR;
    offset_d     = offset_q;
    rtc_value_d  = rtc_value_q;
    match_data_d = match_data_q;
    match_hit_d  = '0;
    case (state_q)
      StOffset: begin
        offset_d     = add_sum;
        match_pend_d = '1;
        load_pend_d  = rtc_io.WrenRTCLR;
      end
      StRtcValue: begin
        rtc_value_d  = rtc_io.RTCEn ? add_sum : '0;
        count_pend_d = rtc_io.CountEdge;
        for (int i = 0; i < int'(NUM_MATCH); i++) begin
          match_hit_d[i] = rtc_io.RTCEn && (rtc_io.CountSync == match_data_q[i*CW +: CW]);
        end
      end
      StMatch: begin
        match_pend_d = (match_pend_q & ~match_sel) | rtc_io.WrenRTCMR;
        for (int i = 0; i < int'(NUM_MATCH); i++) begin
          if (match_sel[i]) match_data_d[i*CW +: CW] = add_sum;
        end
      end
      default: ;
    endcase
    if (test_en) offset_d = test_val;

    // Pending values already fold in live strobes and exclude the request just serviced.
    if (state_q == StOffset)  state_d = StRtcValue;
    else if (load_pend_d)     state_d = StOffset;
    else if (count_pend_d)    state_d = StRtcValue;
    else if (|match_pend_d)   state_d = StMatch;
    else                      state_d = StIdle;

    busy_d = (state_d != StIdle) || load_pend_d || count_pend_d || (|match_pend_d);
  end

  always_ff @(posedge PCLK or posedge POR) begin
    if (POR) begin
      state_q      <= StIdle;
      load_pend_q  <= 1'b0;
      count_pend_q <= 1'b0;
      match_pend_q <= '0;
      offset_q     <= '0;
      rtc_value_q  <= '0;
      match_data_q <= '0;
      match_hit_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_pend_q  <= load_pend_d;
      count_pend_q <= count_pend_d;
      match_pend_q <= match_pend_d;
      offset_q     <= offset_d;
      rtc_value_q  <= rtc_value_d;
      match_data_q <= match_data_d;
      match_hit_q  <= match_hit_d;
      busy_q       <= busy_d;
    end
  end

  assign rtc_io.RtcValue  = rtc_value_q;
  assign rtc_io.Offset    = offset_q;
  assign rtc_io.MatchData = match_data_q;
  assign rtc_io.MatchHit  = match_hit_q;
  assign rtc_io.Busy      = busy_q;

endmodule

// File: doc/rtc_update_mc.md
RTC_UPDATE_MC -- requirements
Module: rtc_update_mc

Interface
REQ-001 SHALL have parameter CW, default 32: counter/data width, legal range 8..64.
REQ-002 SHALL have parameter NUM_MATCH, default 4: number of match channels, legal range 1..16.
REQ-003 SHALL have port PCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port POR  in  1  reset, asynchronous assert and active-high; deassertion is synchronised externally.
REQ-005 SHALL have port CountSync  in  CW  synchronised free-running count.
REQ-006 SHALL have port RTCLR  in  CW  load value.
REQ-007 SHALL have port RTCMR  in  NUM_MATCH*CW  match values; channel i occupies bits [i*CW +: CW].
REQ-008 SHALL have port RTCEn  in  1  RTC enable.
REQ-009 SHALL have port WrenRTCLR  in  1  load-write strobe, one cycle.
REQ-010 SHALL have port WrenRTCMR  in  NUM_MATCH  per-channel match-write strobes.
REQ-011 SHALL have port CountEdge  in  1  counter-increment strobe.
REQ-012 SHALL have port RtcValue  out  CW  current RTC value.
REQ-013 SHALL have port Offset  out  CW  CountSync minus load value.
REQ-014 SHALL have port MatchData  out  NUM_MATCH*CW  equivalent match values, packed as RTCMR.
REQ-015 SHALL have port MatchHit  out  NUM_MATCH  one-cycle match pulses.
REQ-016 SHALL have port Busy  out  1  high while state is not IDLE or any request is pending.

Function
REQ-017 SHALL use one shared CW-bit adder; all arithmetic is modulo 2^CW.
REQ-018 SHALL hold sticky pending bits LoadPend, CountPend and MatchPend[NUM_MATCH], each set by its strobe.
REQ-019 SHALL clear a pending bit when its request is serviced; a strobe arriving in the clearing cycle leaves the bit set.
REQ-020 SHALL run a 4-state FSM: IDLE, OFFSET, RTCVALUE, MATCH; request = pending bit OR live strobe.
REQ-021 SHALL apply priority load > count > match (lowest channel index first) in every state's next-state decision.
REQ-022 SHALL in OFFSET: Offset <= CountSync - RTCLR, set all MatchPend bits, then go to RTCVALUE.
REQ-023 SHALL in RTCVALUE: RtcValue <= CountSync - Offset when RTCEn=1, else 0; clear CountPend.
REQ-024 SHALL in MATCH: service one channel per cycle, MatchData[i] <= RTCMR[i] + Offset.
REQ-025 SHALL remain in MATCH while any MatchPend bit is set, unless a higher-priority request is present; otherwise go to IDLE.
REQ-026 SHALL pulse MatchHit[i] in the cycle after RTCVALUE when RTCEn=1 and CountSync == MatchData[i].
REQ-027 SHALL meet latency for a strobe at edge N in IDLE: state at edge N; for load, Offset at N+1, RtcValue at N+2, channel i MatchData at N+3+i.
REQ-028 SHALL never pulse MatchHit while RTCEn=0.

Reset
REQ-029 SHALL on POR=1 immediately drive state IDLE, all pending bits 0, and outputs RtcValue, Offset, MatchData, MatchHit and Busy to 0.
REQ-030 SHALL discard in-flight requests on reset mid-operation and take no action on them after release.

Configuration
REQ-031 SHALL add ports TESTOFFSET in 1 and RTCTOFFSET in CW when RTC_UPDATE_TESTOFFSET_EN is defined; TESTOFFSET=1 then loads RTCTOFFSET into Offset each cycle, overriding OFFSET-state updates.
REQ-032 SHALL omit those ports when RTC_UPDATE_TESTOFFSET_EN is undefined; Offset then changes only in OFFSET.

Verification
REQ-033 SHALL pass: CW=32, CountSync=0x100, WrenRTCLR with RTCLR=0x1000 -> Offset=0xFFFFF100 at N+1, RtcValue=0x1000 at N+2, Busy=0 at N+7.
REQ-034 SHALL pass: after REQ-033, WrenRTCMR[1] with RTCMR[1]=0x1005 -> MatchData[1]=0x105; CountSync=0x105 with CountEdge -> single MatchHit[1] pulse.
REQ-035 SHALL pass (wrap): CountSync=0, RTCLR=1 -> Offset=0xFFFFFFFF; CountEdge at CountSync=0 -> RtcValue=1.
REQ-036 SHALL pass: WrenRTCLR, CountEdge and WrenRTCMR=4'b1010 in the same cycle -> order OFFSET, RTCVALUE, then MATCH for ch0..3, with no request lost.
REQ-037 SHALL pass: RTCEn=0 with CountEdge at a matching count -> RtcValue=0 and MatchHit=0.
REQ-038 SHALL pass: POR asserted during MATCH -> all outputs 0 at once, and the FSM stays in IDLE after release with no strobes.
